// File: rtl/arb_pkg.sv
// Shared types and the rotating first-set search for the round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scans req upward from ptr, wrapping mod N_REQ; the lowest offset from ptr wins.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [IDX_W-1:0] ptr);
    pick_t            res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/decoder3_8.sv
// Gate-level 3-to-8 one-hot decoder with an active-high enable.
module decoder3_8 (
  input  logic [2:0] a_i,
  input  logic       en_i,
  output logic [7:0] y_o
);
  logic [2:0] a_n;

  not u_n0 (a_n[0], a_i[0]);
  not u_n1 (a_n[1], a_i[1]);
  not u_n2 (a_n[2], a_i[2]);

  and u_y0 (y_o[0], en_i, a_n[2], a_n[1], a_n[0]);
  and u_y1 (y_o[1], en_i, a_n[2], a_n[1], a_i[0]);
  and u_y2 (y_o[2], en_i, a_n[2], a_i[1], a_n[0]);
  and u_y3 (y_o[3], en_i, a_n[2], a_i[1], a_i[0]);
  and u_y4 (y_o[4], en_i, a_i[2], a_n[1], a_n[0]);
  and u_y5 (y_o[5], en_i, a_i[2], a_n[1], a_i[0]);
  and u_y6 (y_o[6], en_i, a_i[2], a_i[1], a_n[0]);
  and u_y7 (y_o[7], en_i, a_i[2], a_i[1], a_i[0]);
endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with bounded hold and a one-cycle TURN gap
// between grants; all outputs come from registers, never directly from req.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter  int MAX_HOLD = 8,
  localparam int HC_W     = $clog2(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt,
  output arb_state_e       state_dbg
);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  pick_t            pick;
  logic             others_waiting;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_idx_d      = gnt_idx_q;
    hold_d         = hold_q;
    pick           = rr_pick(req, ptr_q);
    others_waiting = |(req & ~(N_REQ'(1) << gnt_idx_q));
    case (state_q)
      GRANT: begin
        // Release and forced rotation both hand lowest priority to the current grantee.
        if (!req[gnt_idx_q] || (hold_q == HOLD_MAX && others_waiting)) begin
          state_d = TURN;
          ptr_d   = gnt_idx_q + IDX_W'(1);
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: begin
        if (arb_en && pick.found) begin
          state_d   = GRANT;
          gnt_idx_d = pick.idx;
          hold_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    gnt_valid = (state_q == GRANT);
    gnt_idx   = gnt_idx_q;
    state_dbg = state_q;
  end

  decoder3_8 u_dec (
    .a_i  (gnt_idx_q),
    .en_i (gnt_valid),
    .y_o  (gnt)
  );
endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, release, wrap, preemption, lone holder,
// drop-at-saturation and asynchronous reset with arb_en gating.
module tb_rr_arbiter8;
  import arb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       arb_en;
  logic [7:0] req;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;
  arb_state_e state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter8 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt       (gnt),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [2:0] idx,
                            input logic [7:0] g);
    check_eq({tag, ".valid"}, 32'(gnt_valid), 32'(v));
    check_eq({tag, ".idx"},   32'(gnt_idx),   32'(idx));
    check_eq({tag, ".gnt"},   32'(gnt),       32'(g));
  endtask

  task automatic expect_state(input string tag, input arb_state_e s);
    check_eq({tag, ".state"}, 32'(state_dbg), 32'(s));
  endtask

  // inputs change right after a falling edge; outputs are sampled at falling edges
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    arb_en = 1'b1;
    req    = 8'h00;
    #3;
    expect_out("reset_low", 1'b0, 3'd0, 8'h00);
    expect_state("reset_low", IDLE);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      expect_out("idle", 1'b0, 3'd0, 8'h00);
    end

    // single request on 3, held for 3 sampled cycles
    req = 8'h08;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out("single", 1'b1, 3'd3, 8'h08);
    end
    expect_state("single", GRANT);
    req = 8'h00;
    step();
    expect_out("single_turn", 1'b0, 3'd3, 8'h00);
    expect_state("single_turn", TURN);
    step();
    expect_out("single_idle", 1'b0, 3'd3, 8'h00);
    expect_state("single_idle", IDLE);

    // grant to 5 moves ptr to 6; then 7 beats 0, and ptr wraps to 0
    req = 8'h20;
    step();
    expect_out("g5", 1'b1, 3'd5, 8'h20);
    req = 8'h00;
    step();
    expect_out("g5_turn", 1'b0, 3'd5, 8'h00);
    req = 8'h81;
    step();
    expect_out("wrap7", 1'b1, 3'd7, 8'h80);
    req = 8'h01;
    step();
    expect_out("wrap7_turn", 1'b0, 3'd7, 8'h00);
    step();
    expect_out("wrap0", 1'b1, 3'd0, 8'h01);
    req = 8'h00;
    step();
    expect_out("wrap0_turn", 1'b0, 3'd0, 8'h00);
    step();
    expect_out("wrap_idle", 1'b0, 3'd0, 8'h00);

    // lone holder on 4 (ptr=1) holds past saturation, then 1 preempts
    req = 8'h10;
    for (int k = 0; k < 20; k++) begin
      step();
      expect_out("lone4", 1'b1, 3'd4, 8'h10);
    end
    req = 8'h12;
    step();
    expect_out("lone_preempt_turn", 1'b0, 3'd4, 8'h00);
    step();
    expect_out("lone_next1", 1'b1, 3'd1, 8'h02);
    req = 8'h00;
    step();
    expect_out("lone_turn", 1'b0, 3'd1, 8'h00);
    step();
    expect_out("lone_idle", 1'b0, 3'd1, 8'h00);

    // 0 and 1 both requesting (ptr=2): 8 cycles each, one-cycle gaps
    req = 8'h03;
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 8; k++) begin
        step();
        expect_out($sformatf("preempt_g%0d_c%0d", g, k), 1'b1, 3'(g), 8'(1 << g));
      end
      step();
      expect_out($sformatf("preempt_gap%0d", g), 1'b0, 3'(g), 8'h00);
      expect_state("preempt_gap", TURN);
    end
    step();
    expect_out("preempt_back0", 1'b1, 3'd0, 8'h01);
    req = 8'h00;
    step();
    expect_out("preempt_turn", 1'b0, 3'd0, 8'h00);
    step();
    expect_out("preempt_idle", 1'b0, 3'd0, 8'h00);

    // grantee 1 drops its request on the saturation cycle while 2 waits (ptr=1)
    req = 8'h06;
    for (int k = 0; k < 8; k++) begin
      step();
      expect_out("satdrop1", 1'b1, 3'd1, 8'h02);
    end
    req = 8'h04;
    step();
    expect_out("satdrop_turn", 1'b0, 3'd1, 8'h00);
    step();
    expect_out("satdrop_next2", 1'b1, 3'd2, 8'h04);

    // asynchronous reset in the middle of a cycle clears outputs at once
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 3'd0, 8'h00);
    expect_state("async_rst", IDLE);
    arb_en = 1'b0;
    req    = 8'hFF;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out("en_low", 1'b0, 3'd0, 8'h00);
    end
    arb_en = 1'b1;
    step();
    expect_out("en_high", 1'b1, 3'd0, 8'h01);
    req = 8'h00;
    step();
    expect_out("en_turn", 1'b0, 3'd0, 8'h00);
    step();
    expect_out("en_idle", 1'b0, 3'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
Eight-requester round-robin arbiter that shares one downstream resource, selected through a 3-to-8 one-hot decode. It picks one requester, holds the grant while that requester keeps its request asserted, and forces rotation after a bounded hold time when others are waiting. It sits between the requesters and the shared resource's select/enable lines.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles before preemption when another request is pending; legal range 2..256
HC_W, $clog2(MAX_HOLD), hold-counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
arb_en  input  1  arbitration enable; low blocks new grants
req  input  8  per-requester request, level, one bit per requester
gnt_valid  output  1  a grant is active this cycle
gnt_idx  output  3  index of the current or most recent grantee
gnt  output  8  one-hot grant; all zero when gnt_valid=0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, gnt_valid=0, gnt_idx=0, gnt=8'h00, ptr=0, hold_cnt=0. All outputs are registered or decoded from registers. There is no combinational path from req to any output.
- Priority pointer ptr (3b): the search starts at ptr and scans upward mod 8. The first set req bit wins.
- States:
  - IDLE: if arb_en && |req, go to GRANT. On that edge, gnt_idx=winner, gnt_valid=1, hold_cnt=0. Latency is 1 cycle from req sampled to gnt visible. Otherwise stay in IDLE.
  - GRANT (gnt_valid=1):
    - If req[gnt_idx]==0, go to TURN and set ptr=gnt_idx+1 (mod 8).
    - Else if hold_cnt==MAX_HOLD-1 and |(req & ~(1<<gnt_idx)), preempt: go to TURN and set ptr=gnt_idx+1.
    - Else stay in GRANT. hold_cnt increments and saturates at MAX_HOLD-1, so a lone requester may hold indefinitely and is preempted on the first cycle another request appears after saturation.
    - arb_en does not affect an active grant.
  - TURN (gnt_valid=0, gnt=0): lasts exactly one cycle. The next state is evaluated like IDLE using the updated ptr: GRANT if arb_en && |req, else IDLE.
- gnt_idx holds its last value in IDLE and TURN.
- The one-hot gnt equals the decode of gnt_idx gated by gnt_valid.
- Boundaries:
  - Wrap-around: ptr 7+1 yields 0.
  - The requester that just released or was preempted has the lowest priority on the next pick.
  - All 8 requesting continuously: grants rotate 0,1,...,7,0. Each grant lasts MAX_HOLD cycles, followed by a 1-cycle TURN gap.
  - Grantee drops req on the same cycle hold_cnt saturates: treated as a release. The result is identical to preemption.
  - Reset asserted mid-grant: outputs clear immediately (asynchronous) and ptr returns to 0.
  - arb_en low in IDLE or TURN: no grant is issued and the block goes to or stays in IDLE.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=8 and IDX_W=3.
  - State enum {IDLE, GRANT, TURN}, 2 bits.
  - A function for the rotating first-set search (req, ptr) -> {found, idx}.
- Sub-module: the team's existing 3-to-8 gate-level decoder, decoder3_8. It is instantiated with in=gnt_idx and enable=gnt_valid, and drives gnt.
- The FSM, ptr and hold_cnt live in rr_arbiter8.

Test Plan:
- Reset/idle: rst_n=0 then 1 with req=0 -> gnt_valid=0, gnt=8'h00, gnt_idx=0 for 10 cycles.
- Single request: req=8'h08 held for 3 cycles then dropped -> gnt=8'h08 and gnt_idx=3 from the cycle after req rises, for 3 cycles. One TURN cycle with gnt=0 follows, then IDLE.
- Rotation and wrap: ptr=6 (after a grant to 5 ends), req=8'h81 held -> grant to 7 first, then 0 after release. ptr passes 7 -> 0.
- Preemption: MAX_HOLD=8, req=8'h03 held continuously -> gnt=8'h01 for exactly 8 cycles, 1-cycle gap, gnt=8'h02 for 8 cycles, gap, then 8'h01 again.
- Lone holder: req=8'h10 for 20 cycles, then req[1] set at cycle 20 -> grant to 4 for 20 cycles, preempted at the next edge, gap, then gnt=8'h02.
- Reset mid-grant and enable: gnt=8'h04 active, assert rst_n=0 asynchronously -> gnt=0 without waiting for a clock edge. After release with arb_en=0 and req=8'hFF -> no grant. Raising arb_en -> gnt=8'h01 one cycle later (ptr=0).
